// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle core: opcodes, ALU functs,
// FSM states and instruction field slicers.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LI    = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  function automatic logic [5:0] f_opcode(input logic [31:0] ir);
    return ir[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ir);
    return ir[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ir);
    return ir[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ir);
    return ir[15:11];
  endfunction

  function automatic logic [4:0] f_shamt(input logic [31:0] ir);
    return ir[10:6];
  endfunction

  function automatic logic [5:0] f_funct(input logic [31:0] ir);
    return ir[5:0];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] ir);
    return ir[15:0];
  endfunction

endpackage

// File: rtl/cpu_alu.sv
// Combinational R-type ALU; flags any funct outside the supported set.
module cpu_alu
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [4:0]        shamt,
  input  logic [5:0]        funct,
  output logic [DATA_W-1:0] result,
  output logic              illegal_funct
);

  // Result select by funct; unknown functs produce zero and raise the flag
  always_comb begin
    result        = '0;
    illegal_funct = 1'b0;
    case (funct)
      FN_ADD:  result = a + b;
      FN_SUB:  result = a - b;
      FN_AND:  result = a & b;
      FN_OR:   result = a | b;
      FN_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
      FN_SLL:  result = b << shamt;
      FN_SRL:  result = b >> shamt;
      default: illegal_funct = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_multicycle.sv
// Multi-cycle MIPS-style core sharing one req/ack memory port between
// instruction fetch and load/store. Register file and FSM live here.
module cpu_multicycle
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12,
  parameter int NREGS  = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              illegal,
  output logic [31:0]       instret
);

  localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  state_t            state;
  logic [31:0]       ir;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;
  logic [DATA_W-1:0] res_r;
  logic              mem_req_r;
  logic [DATA_W-1:0] regs [NREGS];

  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [4:0]        rd;
  logic [15:0]       imm;
  logic [RIDX_W-1:0] rs_idx;
  logic [RIDX_W-1:0] rt_idx;
  logic [RIDX_W-1:0] wr_idx;
  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] imm_z;
  logic [DATA_W-1:0] ea_full;
  logic [ADDR_W-1:0] pc_next;
  logic [ADDR_W-1:0] br_pc;
  logic [DATA_W-1:0] alu_res;
  logic              alu_bad;

  assign opcode  = f_opcode(ir);
  assign rs      = f_rs(ir);
  assign rt      = f_rt(ir);
  assign rd      = f_rd(ir);
  assign imm     = f_imm(ir);
  assign rs_idx  = rs[RIDX_W-1:0];
  assign rt_idx  = rt[RIDX_W-1:0];
  assign imm_s   = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_z   = {{(DATA_W-16){1'b0}}, imm};
  assign ea_full = a_r + imm_s;
  assign pc_next = pc + ADDR_W'(1);

  // The request flop sits at 1 through reset so FETCH asks for memory in
  // the very first cycle after release; gating with rst drops it at once.
  assign mem_req = mem_req_r & ~rst;

  cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .a             (a_r),
    .b             (b_r),
    .shamt         (f_shamt(ir)),
    .funct         (f_funct(ir)),
    .result        (alu_res),
    .illegal_funct (alu_bad)
  );

  // Operand read with r0 hardwired to zero, write-back index and branch target
  always_comb begin
    rd_a   = (rs_idx == '0) ? '0 : regs[rs_idx];
    rd_b   = (rt_idx == '0) ? '0 : regs[rt_idx];
    wr_idx = (opcode == OP_RTYPE) ? rd[RIDX_W-1:0] : rt_idx;
    br_pc  = ((opcode == OP_J) || (a_r == b_r)) ? ir[ADDR_W-1:0] : pc_next;
  end

  // Control FSM, datapath registers, register file and memory-port outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= FETCH;
      ir        <= 32'd0;
      a_r       <= '0;
      b_r       <= '0;
      res_r     <= '0;
      mem_req_r <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pc        <= '0;
      halted    <= 1'b0;
      illegal   <= 1'b0;
      instret   <= 32'd0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: begin
          if (mem_ack) begin
            ir        <= mem_rdata[31:0];
            mem_req_r <= 1'b0;
            state     <= DECODE;
          end
        end
        DECODE: begin
          a_r   <= rd_a;
          b_r   <= rd_b;
          state <= EXEC;
        end
        EXEC: begin
          case (opcode)
            OP_RTYPE: begin
              if (alu_bad) begin
                halted  <= 1'b1;
                illegal <= 1'b1;
                state   <= HALT;
              end else begin
                res_r <= alu_res;
                state <= WB;
              end
            end
            OP_LI: begin
              res_r <= imm_z;
              state <= WB;
            end
            OP_LW, OP_SW: begin
              mem_addr  <= ea_full[ADDR_W-1:0];
              mem_we    <= (opcode == OP_SW);
              mem_wdata <= b_r;
              mem_req_r <= 1'b1;
              state     <= MEM;
            end
            OP_BEQ, OP_J: begin
              pc        <= br_pc;
              mem_addr  <= br_pc;
              mem_req_r <= 1'b1;
              instret   <= instret + 32'd1;
              state     <= FETCH;
            end
            OP_HALT: begin
              halted  <= 1'b1;
              instret <= instret + 32'd1;
              state   <= HALT;
            end
            default: begin
              halted  <= 1'b1;
              illegal <= 1'b1;
              state   <= HALT;
            end
          endcase
        end
        MEM: begin
          if (mem_ack) begin
            mem_we <= 1'b0;
            if (opcode == OP_SW) begin
              pc        <= pc_next;
              mem_addr  <= pc_next;
              instret   <= instret + 32'd1;
              state     <= FETCH;
            end else begin
              res_r     <= mem_rdata;
              mem_req_r <= 1'b0;
              state     <= WB;
            end
          end
        end
        WB: begin
          if (wr_idx != '0) regs[wr_idx] <= res_r;
          pc        <= pc_next;
          mem_addr  <= pc_next;
          mem_req_r <= 1'b1;
          instret   <= instret + 32'd1;
          state     <= FETCH;
        end
        HALT: begin
          mem_req_r <= 1'b0;
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

endmodule

// File: doc/cpu_multicycle.md
# cpu_multicycle

Parametrised multi-cycle successor to the single-cycle core. Executes the team's MIPS-style subset (R-type ALU, li, lw, sw, beq, j) plus a new halt opcode, through an explicit FETCH/DECODE/EXECUTE/MEM/WRITEBACK state machine. Instructions and data share one external word-addressed memory port with a req/ack handshake, so wait-state memories are supported. Sits at the top of the CPU hierarchy and replaces the fixed-width, free-running core.

## Interface
- DATA_W, 32, register/memory word width; must be ≥32; instruction is the low 32 bits of the fetched word
- ADDR_W, 12, memory word-address width; PC is ADDR_W bits
- NREGS, 32, register count; power of two, ≤32; register index is the low log2(NREGS) bits of rs/rt/rd

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  1 = write (sw), 0 = read
- mem_addr  out  ADDR_W  word address
- mem_wdata  out  DATA_W  store data
- mem_rdata  in  DATA_W  read data, valid in the mem_ack cycle
- mem_ack  in  1  transfer complete this cycle; may rise in the same cycle as mem_req
- pc  out  ADDR_W  address of the current instruction
- halted  out  1  core stopped
- illegal  out  1  stopped because of an unknown opcode/funct
- instret  out  32  retired-instruction count

## Operation
- Fields: opcode[31:26], rs[25:21], rt[20:16], rd[15:11], shamt[10:6], funct[5:0], imm[15:0], addr[25:0].
- Register 0 reads 0; writes to it are discarded.
- R-type (opcode 0x00): rd ← f(rs, rt). funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt (signed, result 0/1), 0x00 sll rt<<shamt, 0x02 srl rt>>shamt (logical). Arithmetic is modulo 2^DATA_W.
- li 0x0F: rt ← zero-extended imm.
- lw 0x23: rt ← mem[(rs + sext(imm)) mod 2^ADDR_W].
- sw 0x2B: mem[(rs + sext(imm)) mod 2^ADDR_W] ← rt.
- beq 0x04: if rs == rt then PC ← imm[ADDR_W-1:0], else PC ← PC+1.
- j 0x02: PC ← addr[ADDR_W-1:0].
- halt 0x3F: halted = 1; no further memory requests.
- Any other opcode, or an unlisted R-type funct: halted = 1, illegal = 1; no register write.
- All other instructions: PC ← PC+1, wrapping from 2^ADDR_W−1 to 0.
- instret increments once per completed instruction, including halt, excluding illegal; wraps.

## Timing
- States: FETCH → DECODE → EXEC → {MEM, WB, FETCH, HALT}.
  - FETCH: mem_req=1, mem_we=0, mem_addr=pc; waits for mem_ack, then latches IR and goes to DECODE.
  - DECODE: reads register operands.
  - EXEC: ALU op or address computation. beq/j update pc and go to FETCH. lw/sw go to MEM. R-type/li go to WB. halt/illegal go to HALT.
  - MEM: mem_req=1 until mem_ack. lw goes to WB. sw goes to FETCH with pc+1.
  - WB: writes the register, updates pc, goes to FETCH.
  - HALT: absorbing; only rst leaves it.
- Zero-wait latency: beq/j 3 cycles; R-type/li/sw 4; lw 5. Each wait cycle adds one.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1. mem_req deasserts in the cycle after mem_ack.
- On reset: pc=0, all registers=0, state FETCH, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, halted=0, illegal=0, instret=0. The first mem_req is issued in the first cycle after rst deasserts.
- rst asserted mid-transfer aborts immediately. mem_req drops asynchronously, and any returning mem_ack is ignored.
- instret and pc update in the same edge as the final state transition of the instruction.

## Structure
- Package cpu_pkg: opcode and funct localparams, state enum (FETCH, DECODE, EXEC, MEM, WB, HALT), field-slice helper functions.
- Sub-module cpu_alu: combinational, parametrised by DATA_W; inputs a, b, shamt, funct; outputs result and illegal_funct.
- Register file and FSM are inline in cpu_multicycle.

## Test plan
- li r1,5; li r2,7; add r3,r1,r2; halt, with zero-wait memory → r3=12, halted=1, instret=4, total 15 cycles from reset release.
- sw r3,0x100(r0); lw r4,0x100(r0), with memory acking after 3 wait cycles → memory write of 12 at address 0x100; r4=12; each access shows mem_req held for 4 cycles.
- li r1,3; beq r1,r1,0x10 → pc=0x10. Then beq r0,r1,0x20 → pc=0x11.
- li r0,9; add r5,r0,r0 → r5=0. Then sub r6,r0,r1 with r1=1 → r6=0xFFFFFFFF; slt r7,r6,r0 → r7=1.
- Opcode 0x3E fetched at pc 2 → halted=1, illegal=1, instret=2, no further mem_req.
- rst pulsed while mem_req is waiting on a stalled ack → all outputs return to reset values; fetch restarts at address 0.
